registro_botones_pb: RTL and testbench
======================================

# registro_botones_pb

Parametrised, debounced push-button input port for the PicoBlaze `IN` bus, used by the menu/adjust logic. Each raw button is synchronised and debounced, and its press edge is latched as a pending event. The processor reads an encoded event code, with clear-on-read, or a non-destructive status bitmap through two configurable port IDs. `irq` signals any pending event.

## Interface

Parameters:
- `N_BTN`, 4: number of buttons, legal range 1..8.
- `DB_CYCLES`, 1000: consecutive stable cycles needed to accept a level change, ≥2.
- `PORT_EVENT`, 8'h03: port ID of the event-code register (clear-on-read).
- `PORT_STATUS`, 8'h04: port ID of the pending bitmap (read-only, no clear).
- `CODE_BASE`, 8'h04: code returned for button 0; button i returns `CODE_BASE`+i. Must be nonzero, and `CODE_BASE`+`N_BTN`-1 ≤ 255.
- `REP_DELAY`, 500000: auto-repeat first-repeat delay in cycles (used only with the macro).
- `REP_PERIOD`, 100000: auto-repeat interval in cycles (used only with the macro).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `btn` in `N_BTN`: raw asynchronous buttons, active-high.
- `port_id` in 8: PicoBlaze port address.
- `read_strobe` in 1: PicoBlaze read strobe.
- `in_port` out 8: registered read data.
- `irq` out 1: high while any event is pending.

## Operation

- **Synchroniser:** 2-flop synchroniser per button, producing `sync[i]`.
- **Debounce (per channel):**
  - Counter is cleared whenever `sync[i]` == `stable[i]`; otherwise it increments.
  - When the counter reaches `DB_CYCLES`-1 while still differing, `stable[i]` takes `sync[i]` and the counter clears.
- **Events:**
  - A 0→1 transition of `stable[i]` sets `pending[i]`.
  - Releases generate no event.
  - A press on a channel that is already pending is absorbed; events are not counted.
- **Read mux (registered every cycle):**
  - `port_id`==`PORT_EVENT`: if `pending`≠0, return `CODE_BASE`+i for the lowest set index i, and latch i into `rep_idx`; otherwise return 8'h00.
  - `port_id`==`PORT_STATUS`: return `pending` zero-extended to 8 bits.
  - Any other `port_id`: return 8'hFF.
- **Clear:**
  - On a cycle with `read_strobe`=1, `port_id`==`PORT_EVENT` and current `in_port`≠0, clear `pending[rep_idx]`.
  - A clear never touches any other bit.
  - `read_strobe` on `PORT_STATUS` or an unmapped port has no side effect.
- **Set/clear collision:** if a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- **`irq`:** = |`pending` (combinational from the register).
- **Reset:** `in_port`=8'h00, `irq`=0. `pending`, `stable`, synchronisers, debounce counters, `rep_idx` and repeat counters are all 0. A button held through reset reports one press after release of reset plus the debounce time.

## Timing

- `btn[i]` rises and is first sampled at edge 0. Then:
  - `sync[i]`=1 after edge 1.
  - `stable[i]`=1 after edge `DB_CYCLES`+1.
  - `pending[i]` and `irq`=1 after edge `DB_CYCLES`+2.
- Bounces shorter than `DB_CYCLES` cycles are rejected.
- `in_port` has 1-cycle latency from `port_id`, which matches the PicoBlaze 2-cycle `INPUT`.
- The clear takes effect at the edge where `read_strobe` is sampled, so `irq` falls the next cycle if no other bit is pending.
- Back-to-back `INPUT` instructions on `PORT_EVENT` return successive pending codes in ascending index order.

## Configuration

- **Macro:** `BTN_AUTOREPEAT_EN`.
- **Defined:** a per-channel repeat counter runs while `stable[i]`=1.
  - First re-set of `pending[i]` occurs `REP_DELAY` cycles after the press event.
  - Further re-sets occur every `REP_PERIOD` cycles while the button stays held.
  - The counter clears when `stable[i]`=0.
  - A re-set onto an already pending bit is absorbed.
- **Not defined:** no repeat logic is synthesised, the `REP_*` parameters are ignored, and there is exactly one event per debounced press.

## Test plan

All tests use `DB_CYCLES`=4 and the default port IDs and codes.

1. **Reset:** assert `reset` 3 cycles → `in_port`=8'h00, `irq`=0; read `PORT_STATUS` → 8'h00.
2. **Debounce accept/reject:** pulse `btn[2]` for 3 cycles → no event. Hold `btn[2]` → `pending`=4'b0100 after edge 6 and `irq`=1. `INPUT` on 8'h03 → 8'h06, then `pending`=0 and `irq`=0; next `INPUT` → 8'h00.
3. **Priority:** press `btn[0]` and `btn[3]` together → status read returns 8'h09. Event reads return 8'h04, then 8'h07, then 8'h00.
4. **No-side-effect reads:** status read with `read_strobe` → `pending` unchanged. `port_id`=8'h10 → 8'hFF with no clear. Release `btn[1]` after a cleared press → no event; press again → new event 8'h05.
5. **Set/clear collision:** new `btn[1]` press event lands on the same edge as the strobe clearing bit 1 → `pending[1]` stays 1.
6. **Auto-repeat** (`REP_DELAY`=20, `REP_PERIOD`=10): hold `btn[1]` and clear on each event → events at the press, +20 and +30 cycles. Without the macro → only the initial event.

Source files
------------

// File: rtl/registro_botones_pb.sv
// Debounced push-button port for the PicoBlaze IN bus: press events are latched, read as
// clear-on-read codes or as a status bitmap. Define BTN_AUTOREPEAT_EN for hold-to-repeat.
module registro_botones_pb #(
  parameter int         N_BTN       = 4,
  parameter int         DB_CYCLES   = 1000,
  parameter logic [7:0] PORT_EVENT  = 8'h03,
  parameter logic [7:0] PORT_STATUS = 8'h04,
  parameter logic [7:0] CODE_BASE   = 8'h04,
  parameter int         REP_DELAY   = 500000,
  parameter int         REP_PERIOD  = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic [7:0]       port_id,
  input  logic             read_strobe,
  output logic [7:0]       in_port,
  output logic             irq
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (N_BTN < 1 || N_BTN > 8 || DB_CYCLES < 2 || CODE_BASE == 8'h00 ||
      (int'(CODE_BASE) + N_BTN - 1) > 255 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
    $error("registro_botones_pb: illegal parameter combination");
  end

  logic [N_BTN-1:0] sync_meta, sync_q, stable, stable_d, press, set_mask;
  logic [N_BTN-1:0] pending, clr_mask;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [IDX_W-1:0] rep_idx, evt_idx;
  logic [7:0]       evt_code;
  logic             clr_en;

  // Debounce: a level is accepted only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
      stable    <= '0;
      stable_d  <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      stable_d  <= stable;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_q[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_q[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt [N_BTN];
  logic [N_BTN-1:0] rep_first, rep_hit;

  // rep_cnt holds cycles elapsed since the last event on a held channel
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_hit[i] = stable[i] && !press[i] &&
                   (rep_cnt[i] == (rep_first[i] ? REP_W'(REP_DELAY) : REP_W'(REP_PERIOD)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_first <= '1;
      for (int i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!stable[i]) begin
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b1;
        end else if (press[i]) begin
          rep_cnt[i]   <= REP_W'(1);
          rep_first[i] <= 1'b1;
        end else if (rep_hit[i]) begin
          rep_cnt[i]   <= REP_W'(1);
          rep_first[i] <= 1'b0;
        end else begin
          rep_cnt[i]   <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign set_mask = press | rep_hit;
`else
  assign set_mask = press;
`endif

  // Lowest pending index wins the event code
  always_comb begin
    evt_code = 8'h00;
    evt_idx  = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        evt_code = CODE_BASE + 8'(i);
        evt_idx  = IDX_W'(i);
      end
    end
  end

  assign clr_en = read_strobe && (port_id == PORT_EVENT) && (in_port != 8'h00);

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_BTN; i++) clr_mask[i] = clr_en && (rep_idx == IDX_W'(i));
  end

  // A set in the same cycle as its clear wins, so no press is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      in_port <= 8'h00;
      rep_idx <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (port_id == PORT_EVENT) begin
        in_port <= evt_code;
        if (|pending) rep_idx <= evt_idx;
      end else if (port_id == PORT_STATUS) begin
        in_port <= 8'(pending);
      end else begin
        in_port <= 8'hFF;
      end
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_registro_botones_pb.sv
// Directed bench for registro_botones_pb with DB_CYCLES=4; repeat checks follow BTN_AUTOREPEAT_EN.
module tb_registro_botones_pb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       irq;
  logic [7:0] code;
  int         n_vec = 0;
  int         n_err = 0;

  registro_botones_pb #(
    .N_BTN(4), .DB_CYCLES(4), .PORT_EVENT(8'h03), .PORT_STATUS(8'h04),
    .CODE_BASE(8'h04), .REP_DELAY(20), .REP_PERIOD(10)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .port_id(port_id),
    .read_strobe(read_strobe), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Two-cycle PicoBlaze INPUT: code is what the core latches at the end of the strobe cycle
  task automatic do_input(input logic [7:0] port, output logic [7:0] data);
    port_id     = port;
    read_strobe = 1'b0;
    tick();
    data        = in_port;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  initial begin
    reset = 1'b1; btn = 4'b0000; port_id = 8'h00; read_strobe = 1'b0;
    tick(3);
    check("reset_in_port", in_port, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;
    port_id = 8'h04;
    tick();
    check("reset_status", in_port, 8'h00);

    // 3-cycle bounce must be rejected
    btn = 4'b0100;
    tick(3);
    btn = 4'b0000;
    tick(10);
    check("bounce_irq", {7'b0, irq}, 8'h00);
    check("bounce_status", in_port, 8'h00);

    // held press: stable after edge 5, pending after edge 6
    btn = 4'b0100;
    tick(6);
    check("hold_irq_edge5", {7'b0, irq}, 8'h00);
    tick();
    check("hold_irq_edge6", {7'b0, irq}, 8'h01);
    tick();
    check("hold_status", in_port, 8'h04);
    do_input(8'h03, code);
    check("evt_btn2", code, 8'h06);
    check("evt_btn2_irq_clr", {7'b0, irq}, 8'h00);
    do_input(8'h03, code);
    check("evt_empty", code, 8'h00);
    btn = 4'b0000;
    tick(8);
    check("release_no_evt", {7'b0, irq}, 8'h00);

    // simultaneous presses drain in ascending order
    btn = 4'b1001;
    tick(8);
    port_id = 8'h04;
    tick();
    check("prio_status", in_port, 8'h09);
    do_input(8'h03, code);
    check("prio_evt0", code, 8'h04);
    do_input(8'h03, code);
    check("prio_evt3", code, 8'h07);
    do_input(8'h03, code);
    check("prio_empty", code, 8'h00);
    check("prio_irq", {7'b0, irq}, 8'h00);
    btn = 4'b0000;
    tick(8);

    // reads of status or unmapped ports never clear
    btn = 4'b0010;
    tick(8);
    check("b1_irq", {7'b0, irq}, 8'h01);
    port_id = 8'h04;
    tick();
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    tick();
    check("status_strobe_keep", in_port, 8'h02);
    port_id = 8'h10;
    tick();
    check("unmapped_ff", in_port, 8'hFF);
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id = 8'h04;
    tick();
    check("unmapped_keep", in_port, 8'h02);
    do_input(8'h03, code);
    check("b1_evt", code, 8'h05);
    check("b1_irq_clr", {7'b0, irq}, 8'h00);
    btn = 4'b0000;
    tick(8);
    check("b1_release", {7'b0, irq}, 8'h00);
    btn = 4'b0010;
    tick(8);
    do_input(8'h03, code);
    check("b1_repress_evt", code, 8'h05);
    btn = 4'b0000;
    tick(8);

    // collision: bit 1 pending and released; re-press so its rise lands on the clearing edge
    btn = 4'b0010;
    tick(8);
    btn = 4'b0000;
    tick(8);
    check("coll_pre_irq", {7'b0, irq}, 8'h01);
    btn = 4'b0010;
    tick(5);
    port_id = 8'h03;
    tick();
    check("coll_code", in_port, 8'h05);
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id = 8'h04;
    check("coll_irq", {7'b0, irq}, 8'h01);
    tick();
    check("coll_status", in_port, 8'h02);
    do_input(8'h03, code);
    check("coll_drain", code, 8'h05);
    check("coll_irq_clr", {7'b0, irq}, 8'h00);
    btn = 4'b0000;
    tick(8);

    // auto-repeat: event edge E = 6 edges after press; after do_input we sit at E+2
    btn = 4'b0010;
    tick(7);
    check("rep_first_irq", {7'b0, irq}, 8'h01);
    do_input(8'h03, code);
    check("rep_first_code", code, 8'h05);
`ifdef BTN_AUTOREPEAT_EN
    tick(17);
    check("rep_e19", {7'b0, irq}, 8'h00);
    tick();
    check("rep_e20", {7'b0, irq}, 8'h01);
    do_input(8'h03, code);
    check("rep_e20_code", code, 8'h05);
    tick(7);
    check("rep_e29", {7'b0, irq}, 8'h00);
    tick();
    check("rep_e30", {7'b0, irq}, 8'h01);
    do_input(8'h03, code);
    check("rep_e30_code", code, 8'h05);
`else
    tick(40);
    check("norep_irq", {7'b0, irq}, 8'h00);
    port_id = 8'h04;
    tick();
    check("norep_status", in_port, 8'h00);
`endif
    btn = 4'b0000;
    tick(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
